pb_event_arbiter: RTL and testbench
===================================

Name: pb_event_arbiter

Overview:
- Shares the single game-logic "button hit" input among N debounced push-buttons in Whack-A-Mole.
- Inputs are the per-button PB_state outputs of the debouncers: active-high, synchronous to clk.
- Detects press edges, latches each as a pending request and grants one at a time using round-robin priority.
- Each grant is delivered as a button index over a valid/ready handshake, so no simultaneous press is lost or merged.

Parameters:
- N_BTN, 4, number of buttons/requesters (2..16).
- IDX_W, 2, width of evt_idx; must satisfy 2**IDX_W >= N_BTN.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- btn_state  input  N_BTN  debounced button levels, 1 = pressed, synchronous to clk.
- evt_valid  output  1  an event is offered.
- evt_idx  output  IDX_W  index of the offered button.
- evt_rel  output  1  1 = release event, 0 = press event; always 0 unless PB_RELEASE_EVT_EN.
- evt_ready  input  1  consumer accepts the offered event.
- drop_cnt  output  DROP_W  count of coalesced (lost) events, saturating.

Behaviour:
Reset (async, rst_n=0):
- evt_valid=0, evt_idx=0, evt_rel=0, drop_cnt=0, pending=0.
- prev_state=all ones, so a button held through reset yields no press event.
- rr_ptr=N_BTN-1, so button 0 has top priority first.

Edge detect (every posedge):
- rise[i] = btn_state[i] & ~prev_state[i].
- prev_state <= btn_state.
- rise[i] sets pending[i].

Coalescing:
- If rise[i] occurs while pending[i] is already 1 and is not being cleared this cycle, the pending bit stays 1 and drop_cnt increments.
- drop_cnt saturates at all ones.
- An edge on the button whose event is currently held in the output register is not a drop; it sets pending[i].

State machine:
- IDLE (evt_valid=0):
  - If any pending bit is set, go to OFFER.
  - Winner = first set bit scanning rr_ptr+1, rr_ptr+2, … with wrap modulo N_BTN, ending at rr_ptr.
  - Load evt_idx=winner, clear pending[winner], rr_ptr<=winner, evt_valid<=1.
- OFFER (evt_valid=1):
  - evt_idx and evt_rel are held stable while evt_ready=0.
  - On evt_valid & evt_ready: if other pending bits are set, load the next winner on the same edge (back-to-back, valid stays 1); otherwise evt_valid<=0 and go to IDLE.
  - Pending bits used for the winner are the registered values, not this cycle's rise.

Same-cycle rules:
- If rise[i] arrives on the same edge that pending[i] is cleared by a grant, set wins: pending[i] stays 1 and no drop is counted.

Latency:
- btn_state rising edge sampled at edge k gives pending at k.
- evt_valid is high after edge k+1 when the arbiter is idle, i.e. 2 cycles from input change to visible valid.

Throughput:
- One event per cycle with evt_ready tied high.

Fairness:
- Any pending button is granted within N_BTN transfers.

Reset mid-offer:
- The event is lost, all state returns to reset values and no drop is counted.

Optional Feature:
- Macro: PB_RELEASE_EVT_EN.
- Defined:
  - A second pending vector rel_pending is set on falls (~btn_state & prev_state) and has its own coalescing into the same drop_cnt.
  - The arbiter treats request slot 2*i as the press of button i and 2*i+1 as the release of button i, with round-robin over the 2*N_BTN slots.
  - evt_rel=1 for release grants.
- Undefined:
  - Falls are ignored, no rel_pending logic exists and evt_rel is tied 0.

Test Plan:
- Reset with btn_state=4'b0010 held, release rst_n → no event ever; evt_valid=0 and drop_cnt=0 for 20 cycles.
- Single press btn 2 (0→1) with evt_ready=1 → evt_valid=1 for exactly one cycle, 2 cycles after the input change; evt_idx=2, evt_rel=0.
- Buttons 0, 1, 3 rise on the same cycle, evt_ready=1 → back-to-back events idx 0, 1, 3 on consecutive cycles, then evt_valid=0.
- evt_ready=0, btn 1 pressed, released and pressed again twice while its first event is held → idx 1 held stable; after ready rises, one further idx 1 event follows; drop_cnt=1.
- Round-robin: after a grant to idx 3, buttons 0 and 3 both pending → the next grant is idx 0.
- PB_RELEASE_EVT_EN: btn 0 press then release with ready=1 → events (idx 0, rel 0) then (idx 0, rel 1); without the macro only the press event appears.

Source files
------------

// File: rtl/pb_event_arbiter.sv
// pb_event_arbiter: turns debounced push-button levels into a stream of
// button-index events on a valid/ready handshake. Press edges are latched
// as pending requests and granted one at a time in round-robin order.
// Optional feature macro: PB_RELEASE_EVT_EN (also report release events,
// request slot 2*i = press of button i, slot 2*i+1 = release of button i).
module pb_event_arbiter #(
   parameter int unsigned N_BTN  = 4,
   parameter int unsigned IDX_W  = 2,
   parameter int unsigned DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_BTN-1:0]  btn_state,
   output logic              evt_valid,
   output logic [IDX_W-1:0]  evt_idx,
   output logic              evt_rel,
   input  logic              evt_ready,
   output logic [DROP_W-1:0] drop_cnt
);

`ifdef PB_RELEASE_EVT_EN
   localparam int unsigned NS = 2 * N_BTN;
`else
   localparam int unsigned NS = N_BTN;
`endif
   localparam int unsigned SLOT_W = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                grant;

   logic [N_BTN-1:0]    prev_state;
   logic [N_BTN-1:0]    rise;
   logic [N_BTN-1:0]    pending;
   logic [N_BTN-1:0]    pending_d;
   logic [N_BTN-1:0]    press_clr;
   logic [N_BTN-1:0]    press_drop;

   logic [NS-1:0]       req;
   logic [NS-1:0]       clr;
   logic [SLOT_W-1:0]   rr_ptr;
   logic [SLOT_W-1:0]   win_slot;
   logic                win_found;
   logic [SLOT_W:0]     cand;

   logic [DROP_W-1:0]   drop_d;

`ifdef PB_RELEASE_EVT_EN
   logic [N_BTN-1:0]    fall;
   logic [N_BTN-1:0]    rel_pending;
   logic [N_BTN-1:0]    rel_pending_d;
   logic [N_BTN-1:0]    rel_clr;
   logic [N_BTN-1:0]    rel_drop;
`endif

   // Edge detection against the previous sampled levels
   always_comb begin
      rise = btn_state & ~prev_state;
`ifdef PB_RELEASE_EVT_EN
      fall = ~btn_state & prev_state;
`endif
   end

   // Map pending vectors onto request slots for the arbiter
   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
`ifdef PB_RELEASE_EVT_EN
         req[2*i]   = pending[i];
         req[2*i+1] = rel_pending[i];
`else
         req[i]     = pending[i];
`endif
      end
   end

   // Round-robin winner: first request after rr_ptr, wrapping, ending at rr_ptr
   always_comb begin
      win_found = 1'b0;
      win_slot  = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NS; k++) begin
         cand = {1'b0, rr_ptr} + (SLOT_W+1)'(k);
         if (cand >= (SLOT_W+1)'(NS)) begin
            cand = cand - (SLOT_W+1)'(NS);
         end
         if (!win_found && req[cand[SLOT_W-1:0]]) begin
            win_found = 1'b1;
            win_slot  = cand[SLOT_W-1:0];
         end
      end
   end

   // Next-state and grant decision
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant   = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               if (win_found) begin
                  grant = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Slot clear mask for the granted request, split back to per-button vectors
   always_comb begin
      clr       = '0;
      press_clr = '0;
      if (grant) begin
         clr = NS'(1) << win_slot;
      end
      for (int unsigned i = 0; i < N_BTN; i++) begin
`ifdef PB_RELEASE_EVT_EN
         press_clr[i] = clr[2*i];
`else
         press_clr[i] = clr[i];
`endif
      end
`ifdef PB_RELEASE_EVT_EN
      rel_clr = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         rel_clr[i] = clr[2*i+1];
      end
`endif
   end

   // Pending update: a new edge beats a same-cycle grant clear; edges on
   // an already pending, uncleared request are coalesced and counted
   always_comb begin
      pending_d  = (pending & ~press_clr) | rise;
      press_drop = rise & pending & ~press_clr;
`ifdef PB_RELEASE_EVT_EN
      rel_pending_d = (rel_pending & ~rel_clr) | fall;
      rel_drop      = fall & rel_pending & ~rel_clr;
`endif
   end

   // Saturating drop counter, one step per coalesced edge
   always_comb begin
      drop_d = drop_cnt;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (press_drop[i] && (drop_d != '1)) begin
            drop_d = drop_d + DROP_W'(1);
         end
`ifdef PB_RELEASE_EVT_EN
         if (rel_drop[i] && (drop_d != '1)) begin
            drop_d = drop_d + DROP_W'(1);
         end
`endif
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Edge history, pending requests, pointer and drop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_state <= '1;
         pending    <= '0;
         rr_ptr     <= SLOT_W'(NS - 1);
         drop_cnt   <= '0;
      end else begin
         prev_state <= btn_state;
         pending    <= pending_d;
         drop_cnt   <= drop_d;
         if (grant) begin
            rr_ptr <= win_slot;
         end
      end
   end

   // Output event register: loaded on every grant, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_idx   <= '0;
      end else begin
         evt_valid <= (state_d == OFFER);
         if (grant) begin
`ifdef PB_RELEASE_EVT_EN
            evt_idx <= IDX_W'(win_slot >> 1);
`else
            evt_idx <= IDX_W'(win_slot);
`endif
         end
      end
   end

`ifdef PB_RELEASE_EVT_EN
   // Release bookkeeping and event type flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rel_pending <= '0;
         evt_rel     <= 1'b0;
      end else begin
         rel_pending <= rel_pending_d;
         if (grant) begin
            evt_rel <= win_slot[0];
         end
      end
   end
`else
   assign evt_rel = 1'b0;
`endif

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Scoreboard bench for pb_event_arbiter (default build, 4 buttons).
// Inputs are driven and outputs sampled at the falling edge.
module tb_pb_event_arbiter;

   localparam int unsigned N_BTN  = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned DROP_W = 8;

   logic              clk;
   logic              rst_n;
   logic [N_BTN-1:0]  btn_state;
   logic              evt_valid;
   logic [IDX_W-1:0]  evt_idx;
   logic              evt_rel;
   logic              evt_ready;
   logic [DROP_W-1:0] drop_cnt;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             rel;
   } evt_t;

   typedef struct {
      evt_t ev;
      int   cyc;
   } obs_t;

   evt_t exp_q[$];
   obs_t obs_q[$];
   int   total;
   int   bad;
   int   cyc;
   int   valid_cycles;
   int   model_last;

   pb_event_arbiter #(
      .N_BTN  (N_BTN),
      .IDX_W  (IDX_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_state (btn_state),
      .evt_valid (evt_valid),
      .evt_idx   (evt_idx),
      .evt_rel   (evt_rel),
      .evt_ready (evt_ready),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round-robin reference: first set bit after 'last', wrapping
   function automatic int rr_pick(input logic [N_BTN-1:0] mask, input int last);
      for (int k = 1; k <= int'(N_BTN); k++) begin
         int s;
         s = (last + k) % int'(N_BTN);
         if (mask[s]) return s;
      end
      return -1;
   endfunction

   // Push the expected press grants for a set of simultaneous requests
   task automatic push_presses(input logic [N_BTN-1:0] mask_in);
      logic [N_BTN-1:0] mask;
      int w;
      evt_t e;
      mask = mask_in;
      while (mask != '0) begin
         w = rr_pick(mask, model_last);
         e.idx = IDX_W'(w);
         e.rel = 1'b0;
         exp_q.push_back(e);
         mask[w] = 1'b0;
         model_last = w;
      end
   endtask

   task automatic begin_window();
      cyc = 0;
      valid_cycles = 0;
      obs_q.delete();
   endtask

   // Sample the current falling edge, then advance one cycle
   task automatic run_cycles(input int n);
      obs_t o;
      for (int c = 0; c < n; c++) begin
         if (evt_valid === 1'b1) valid_cycles++;
         if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            o.ev.idx = evt_idx;
            o.ev.rel = evt_rel;
            o.cyc    = cyc;
            obs_q.push_back(o);
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn_state = 4'b0010;
      evt_ready = 1'b1;
      model_last = int'(N_BTN) - 1;
      @(negedge clk);
      run_cycles(3);
      total++;
      if (evt_valid !== 1'b0 || evt_idx !== '0 || evt_rel !== 1'b0 || drop_cnt !== '0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%b idx=%0d rel=%b drop=%0d required 0 0 0 0",
                  evt_valid, evt_idx, evt_rel, drop_cnt);
      end
      rst_n = 1'b1;
      begin_window();
      run_cycles(20);
      total++;
      if (valid_cycles !== 0) begin
         bad++;
         $display("FAIL reset_held_btn got %0d valid cycles required 0", valid_cycles);
      end
      total++;
      if (drop_cnt !== '0) begin
         bad++;
         $display("FAIL reset_drop got %0d required 0", drop_cnt);
      end
      btn_state = '0;
      run_cycles(3);
   endtask

   task automatic test_back_to_back();
      evt_t e;
      obs_t o;
      int j;
      begin_window();
      btn_state = 4'b1011;
      push_presses(4'b1011);
      run_cycles(10);
      j = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL b2b_evt%0d got none required idx=%0d", j, e.idx);
         end else begin
            o = obs_q.pop_front();
            if (o.ev !== e || o.cyc !== 2 + j) begin
               bad++;
               $display("FAIL b2b_evt%0d got idx=%0d rel=%b cyc=%0d required idx=%0d rel=%b cyc=%0d",
                        j, o.ev.idx, o.ev.rel, o.cyc, e.idx, e.rel, 2 + j);
            end
         end
         j++;
      end
      total++;
      if (obs_q.size() != 0 || valid_cycles !== 3) begin
         bad++;
         $display("FAIL b2b_count got extra=%0d valid_cycles=%0d required 0 and 3",
                  obs_q.size(), valid_cycles);
      end
      btn_state = '0;
      run_cycles(2);
   endtask

   task automatic test_round_robin();
      evt_t e;
      obs_t o;
      int j;
      begin_window();
      btn_state = 4'b1001;
      push_presses(4'b1001);
      run_cycles(8);
      j = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL rr_evt%0d got none required idx=%0d", j, e.idx);
         end else begin
            o = obs_q.pop_front();
            if (o.ev !== e) begin
               bad++;
               $display("FAIL rr_evt%0d got idx=%0d rel=%b required idx=%0d rel=%b",
                        j, o.ev.idx, o.ev.rel, e.idx, e.rel);
            end
         end
         j++;
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL rr_extra got %0d extra events required 0", obs_q.size());
      end
      btn_state = '0;
      run_cycles(2);
   endtask

   task automatic test_single();
      evt_t e;
      obs_t o;
      begin_window();
      btn_state = 4'b0100;
      push_presses(4'b0100);
      run_cycles(8);
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
         bad++;
         $display("FAIL single_evt got none required idx=%0d", e.idx);
      end else begin
         o = obs_q.pop_front();
         if (o.ev !== e || o.cyc !== 2) begin
            bad++;
            $display("FAIL single_evt got idx=%0d rel=%b cyc=%0d required idx=%0d rel=%b cyc=2",
                     o.ev.idx, o.ev.rel, o.cyc, e.idx, e.rel);
         end
      end
      total++;
      if (valid_cycles !== 1 || obs_q.size() != 0) begin
         bad++;
         $display("FAIL single_width got valid_cycles=%0d extra=%0d required 1 and 0",
                  valid_cycles, obs_q.size());
      end
      btn_state = '0;
      run_cycles(2);
   endtask

   task automatic test_coalesce();
      evt_t e;
      obs_t o;
      int j;
      evt_ready = 1'b0;
      begin_window();
      btn_state = 4'b0010;
      run_cycles(3);
      for (int r = 0; r < 2; r++) begin
         btn_state = 4'b0000;
         run_cycles(2);
         btn_state = 4'b0010;
         run_cycles(2);
         total++;
         if (evt_valid !== 1'b1 || evt_idx !== 2'd1 || evt_rel !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable%0d got valid=%b idx=%0d rel=%b required 1 1 0",
                     r, evt_valid, evt_idx, evt_rel);
         end
      end
      total++;
      if (drop_cnt !== 8'd1) begin
         bad++;
         $display("FAIL hold_drop got %0d required 1", drop_cnt);
      end
      push_presses(4'b0010);
      push_presses(4'b0010);
      evt_ready = 1'b1;
      begin_window();
      run_cycles(6);
      j = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL hold_evt%0d got none required idx=%0d", j, e.idx);
         end else begin
            o = obs_q.pop_front();
            if (o.ev !== e || o.cyc !== j) begin
               bad++;
               $display("FAIL hold_evt%0d got idx=%0d rel=%b cyc=%0d required idx=%0d rel=%b cyc=%0d",
                        j, o.ev.idx, o.ev.rel, o.cyc, e.idx, e.rel, j);
            end
         end
         j++;
      end
      total++;
      if (obs_q.size() != 0 || valid_cycles !== 2 || evt_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_after got extra=%0d valid_cycles=%0d valid=%b required 0 2 0",
                  obs_q.size(), valid_cycles, evt_valid);
      end
      btn_state = '0;
      run_cycles(2);
   endtask

   task automatic test_reset_mid_offer();
      evt_ready = 1'b0;
      btn_state = 4'b1000;
      run_cycles(3);
      total++;
      if (evt_valid !== 1'b1 || evt_idx !== 2'd3) begin
         bad++;
         $display("FAIL midrst_offer got valid=%b idx=%0d required 1 3", evt_valid, evt_idx);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (evt_valid !== 1'b0 || drop_cnt !== '0) begin
         bad++;
         $display("FAIL midrst_clear got valid=%b drop=%0d required 0 0", evt_valid, drop_cnt);
      end
      @(negedge clk);
      run_cycles(2);
      rst_n = 1'b1;
      model_last = int'(N_BTN) - 1;
      evt_ready = 1'b1;
      begin_window();
      run_cycles(8);
      total++;
      if (valid_cycles !== 0 || drop_cnt !== '0) begin
         bad++;
         $display("FAIL midrst_after got valid_cycles=%0d drop=%0d required 0 0",
                  valid_cycles, drop_cnt);
      end
      btn_state = '0;
      run_cycles(2);
   endtask

   task automatic test_release_ignored();
      evt_t e;
      obs_t o;
      begin_window();
      btn_state = 4'b0001;
      push_presses(4'b0001);
      run_cycles(4);
      btn_state = 4'b0000;
      run_cycles(6);
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
         bad++;
         $display("FAIL release_press got none required idx=%0d rel=0", e.idx);
      end else begin
         o = obs_q.pop_front();
         if (o.ev !== e) begin
            bad++;
            $display("FAIL release_press got idx=%0d rel=%b required idx=%0d rel=%b",
                     o.ev.idx, o.ev.rel, e.idx, e.rel);
         end
      end
      total++;
      if (obs_q.size() != 0 || valid_cycles !== 1) begin
         bad++;
         $display("FAIL release_extra got extra=%0d valid_cycles=%0d required 0 1",
                  obs_q.size(), valid_cycles);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      valid_cycles = 0;
      test_reset();
      test_back_to_back();
      test_round_robin();
      test_single();
      test_coalesce();
      test_reset_mid_offer();
      test_release_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
